melody_sequencer: RTL

Sequences buzzer tones for the Tamagotchi by programming the frequency input of the programmable clock divider (freq_out, tone_en) from a fixed note ROM. It accepts melody requests from game logic (happy, hungry, sleep, alarm), plays each note for a ROM-defined duration with an inter-note gap, and arbitrates so that the alarm melody preempts others. It sits between the game FSM and the divider/buzzer gate.

---
 rtl/melody_pkg.sv | 41 ++++
 rtl/melody_sequencer_if.sv | 20 ++
 rtl/ms_tick_gen.sv | 27 ++
 rtl/melody_sequencer.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/melody_pkg.sv
// Shared types and the fixed note ROM for the buzzer melody sequencer.
package melody_pkg;

    typedef enum logic [2:0] {StIdle, StLoad, StPlay, StGap, StDone} state_e;

    localparam logic [1:0] MEL_HAPPY  = 2'd0;
    localparam logic [1:0] MEL_HUNGRY = 2'd1;
    localparam logic [1:0] MEL_SLEEP  = 2'd2;
    localparam logic [1:0] MEL_ALARM  = 2'd3;

    localparam int unsigned FreqW = 12;
    localparam int unsigned DurW  = 8;

    typedef struct packed {
        logic [FreqW-1:0] freq;  // Hz, 0 = rest
        logic [DurW-1:0]  dur;   // 10 ms units, 0 = end marker
    } note_t;

    // Address is {melody, slot}; unlisted slots read as end markers.
    function automatic note_t note_rom(input logic [4:0] addr);
        note_t n;
        n = '0;
        case (addr)
            5'd0:  n = '{freq: 12'd523, dur: 8'd10};
            5'd1:  n = '{freq: 12'd659, dur: 8'd10};
            5'd2:  n = '{freq: 12'd784, dur: 8'd20};
            5'd8:  n = '{freq: 12'd440, dur: 8'd15};
            5'd9:  n = '{freq: 12'd0,   dur: 8'd5};
            5'd10: n = '{freq: 12'd440, dur: 8'd15};
            5'd11: n = '{freq: 12'd349, dur: 8'd30};
            5'd16: n = '{freq: 12'd392, dur: 8'd20};
            5'd17: n = '{freq: 12'd330, dur: 8'd20};
            5'd18: n = '{freq: 12'd262, dur: 8'd40};
            5'd24, 5'd26, 5'd28, 5'd30: n = '{freq: 12'd880, dur: 8'd5};
            5'd25, 5'd27, 5'd29, 5'd31: n = '{freq: 12'd0,   dur: 8'd5};
            default: n = '0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/melody_sequencer_if.sv
// Request/tone bundle between game logic and the melody sequencer.
interface melody_sequencer_if;
    logic        play_req;
    logic [1:0]  melody_sel;
    logic        stop;
    logic [31:0] freq_out;
    logic        tone_en;
    logic        busy;
    logic        done;

    modport master (
        output play_req, melody_sel, stop,
        input  freq_out, tone_en, busy, done
    );

    modport slave (
        input  play_req, melody_sel, stop,
        output freq_out, tone_en, busy, done
    );
endinterface

// File: rtl/ms_tick_gen.sv
// 1 ms strobe derived from CLK_FREQ, with synchronous clear restarting the period.
module ms_tick_gen #(
    parameter int unsigned CLK_FREQ = 50000000
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);
    localparam int unsigned Div  = (CLK_FREQ / 1000 > 0) ? CLK_FREQ / 1000 : 1;
    localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(Div - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick = ~clear & (cnt_q == CntMax);

    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (clear || tick) cnt_d = '0;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/melody_sequencer.sv
// Plays ROM melodies as freq_out/tone_en with inter-note gaps; alarm preempts others.
// Optional MELODY_LOOP_EN: the alarm melody repeats until stopped.
module melody_sequencer
    import melody_pkg::*;
#(
    parameter int unsigned CLK_FREQ         = 50000000,
    parameter int unsigned GAP_MS           = 20,
    parameter int unsigned NOTES_PER_MELODY = 8
) (
    input logic               clk_in,
    input logic               rst_n,
    melody_sequencer_if.slave bus
);
    localparam int unsigned IdxW    = $clog2(NOTES_PER_MELODY + 1);
    localparam int unsigned DurCntW = 12;
    localparam int unsigned GapW    = 16;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NOTES_PER_MELODY - 1);

    state_e              state_q, state_d;
    logic [1:0]          sel_q, sel_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [DurCntW-1:0]  dur_q, dur_d;
    logic [GapW-1:0]     gap_q, gap_d;
    logic [31:0]         freq_q, freq_d;
    logic                tone_q, tone_d;
    logic                busy_q, busy_d;
    logic                tick, tick_clear, preempt, loop_alarm;
    logic [2:0]          rom_idx;
    note_t               note;

    assign rom_idx = 3'(idx_q);
    assign note    = note_rom({sel_q, rom_idx});

`ifdef MELODY_LOOP_EN
    assign loop_alarm = (sel_q == MEL_ALARM);
`else
    assign loop_alarm = 1'b0;
`endif

    assign preempt    = bus.play_req && (bus.melody_sel == MEL_ALARM) && (sel_q != MEL_ALARM);
    assign tick_clear = (state_q == StIdle) || (state_q == StLoad) || (state_q == StDone);

    ms_tick_gen #(.CLK_FREQ(CLK_FREQ)) u_tick (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .clear  (tick_clear),
        .tick   (tick)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        idx_d   = idx_q;
        dur_d   = dur_q;
        gap_d   = gap_q;
        freq_d  = freq_q;
        tone_d  = tone_q;
        busy_d  = busy_q;

        unique case (state_q)
            StIdle: begin
                if (bus.play_req && !bus.stop) begin
                    sel_d   = bus.melody_sel;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (note.dur == '0) begin
                    freq_d = '0;
                    tone_d = 1'b0;
                    if (loop_alarm) begin
                        idx_d   = '0;
                        state_d = StLoad;
                    end else begin
                        state_d = StDone;
                    end
                end else begin
                    freq_d  = 32'(note.freq);
                    tone_d  = (note.freq != '0);
                    dur_d   = DurCntW'(note.dur) * DurCntW'(10);
                    state_d = StPlay;
                end
            end
            StPlay: begin
                if (tick) begin
                    dur_d = dur_q - DurCntW'(1);
                    if (dur_q == DurCntW'(1)) begin
                        freq_d  = '0;
                        tone_d  = 1'b0;
                        gap_d   = GapW'(GAP_MS);
                        state_d = StGap;
                    end
                end
            end
            StGap: begin
                // gap_q <= 1 also covers a zero-length gap configuration
                if (tick) begin
                    gap_d = gap_q - GapW'(1);
                    if (gap_q <= GapW'(1)) begin
                        if (idx_q == LastIdx) begin
                            idx_d   = '0;
                            state_d = loop_alarm ? StLoad : StDone;
                        end else begin
                            idx_d   = idx_q + IdxW'(1);
                            state_d = StLoad;
                        end
                    end
                end
            end
            StDone: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Abort and alarm preemption override the normal sequencing while playing.
        if (state_q == StLoad || state_q == StPlay || state_q == StGap) begin
            if (bus.stop) begin
                freq_d  = '0;
                tone_d  = 1'b0;
                state_d = StDone;
            end else if (preempt) begin
                sel_d   = MEL_ALARM;
                idx_d   = '0;
                state_d = StLoad;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sel_q   <= '0;
            idx_q   <= '0;
            dur_q   <= '0;
            gap_q   <= '0;
            freq_q  <= '0;
            tone_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            idx_q   <= idx_d;
            dur_q   <= dur_d;
            gap_q   <= gap_d;
            freq_q  <= freq_d;
            tone_q  <= tone_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.freq_out = freq_q;
    assign bus.tone_en  = tone_q;
    assign bus.busy     = busy_q;
    assign bus.done     = (state_q == StDone);
endmodule
